instr_fetch_queue: RTL
======================

# instr_fetch_queue

Parametrised instruction-fetch front end for the next-generation core. It owns the program counter and issues word fetches to a synchronous instruction memory with one-cycle read latency. It buffers returned instructions with their PCs in a DEPTH-entry queue, and hands them to decode through a valid/ready port. It adds the features the single-cycle datapath lacks: back-pressure from decode, prefetch buffering, and branch/jump redirect with queue flush.

## Interface
- PC_W, 6: PC/address width in bits; the PC wraps modulo 2^PC_W.
- INSTR_W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, minimum 2.
- PC_STEP, 1: PC increment per fetch (1 = word addressed).
- RESET_PC, 0: fetch PC after reset.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  fetch enable; 0 stops new requests, while queue drain and in-flight returns continue.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new fetch PC, sampled when redirect=1.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  PC_W  fetch address, equal to the current fetch PC.
- imem_rdata  in  INSTR_W  instruction for the request issued in the previous cycle.
- deq_valid  out  1  queue head holds a valid entry.
- deq_ready  in  1  decode accepts the head this cycle.
- deq_instr  out  INSTR_W  head instruction; 0 when deq_valid=0.
- deq_pc  out  PC_W  head PC; 0 when deq_valid=0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- pc_out  out  PC_W  current fetch PC, for observation.

## Operation
- State:
  - fetch PC `fpc`
  - queue storage, rd/wr pointers and count
  - in-flight flag `infl` and its PC `infl_pc`
- Request rule: imem_req = rst & enable & ~redirect & (count + infl < DEPTH). When a request is issued: infl<=1, infl_pc<=fpc, fpc<=fpc+PC_STEP (mod 2^PC_W).
- Return: if infl=1 and there is no redirect this cycle, write {imem_rdata, infl_pc} at the write pointer, then advance it. If no new request is issued, infl<=0.
- Dequeue: when deq_valid & deq_ready & ~redirect, advance the read pointer.
- Simultaneous enqueue and dequeue is legal, with count unchanged; full and empty behave the same way.
- The credit rule guarantees a return never finds the queue full, so returns are never dropped except by a flush.
- Redirect has highest priority:
  - fpc<=redirect_pc, count<=0, pointers<=0, infl<=0.
  - The in-flight return and any dequeue in the same cycle are discarded.
  - No request is issued in the redirect cycle.
- enable=0 mid-stream: the in-flight return still lands and queued entries still drain. fpc holds.
- Pointers wrap modulo DEPTH. count saturates at neither end; overflow and underflow are prevented by the rules above.
- Reset (rst=0, asynchronous):
  - fpc=RESET_PC; count=0; infl=0; pointers=0.
  - imem_req=0, deq_valid=0, deq_instr=0, deq_pc=0.
  - Queue storage need not be cleared, because outputs are masked by deq_valid.

## Timing
- Cycle t: imem_req=1, imem_addr=A. Cycle t+1: imem_rdata holds mem[A], and it is written at the end of t+1. Cycle t+2: deq_valid=1, deq_pc=A.
- With enable rising at cycle 0 and deq_ready=1 throughout, the first deq_valid appears in cycle 2. After that the queue sustains 1 instruction per cycle.
- With deq_ready=0, requests stop once count+infl reaches DEPTH. No further request is issued until a dequeue frees a slot; the slot is freed the cycle after the dequeue edge.
- Redirect in cycle r: the queue is empty in r+1 and the first request to redirect_pc is issued in r+1. The new instruction appears at the head in r+3.
- Deassertion of reset takes effect at the next rising edge; imem_req may assert in the first cycle after release if enable=1.

## Test plan
- Reset/defaults: hold rst=0 with enable=1. Required: imem_req=0, deq_valid=0, count=0, pc_out=0. Release rst: imem_addr=0 in the first cycle, 1 in the next.
- Streaming: mem[i]=32'hA000_0000+i, enable=1, deq_ready=1. Required: deq_pc=0,1,2,… on consecutive cycles from cycle 2, each with deq_instr=A000_000i.
- Back-pressure: deq_ready=0. Required: count reaches 4 and imem_req stays 0 afterwards. Then set deq_ready=1: entries PC 0..3 drain in order and fetch resumes at PC 4 with no gaps or duplicates.
- Redirect: while streaming, pulse redirect with redirect_pc=6'h20 while an entry is in flight. Required: count=0 the next cycle, the stale return is not enqueued, and deq_pc=0x20 appears 3 cycles after the pulse.
- Wrap: redirect_pc=6'h3E with PC_STEP=1. Required: deq_pc sequence is 0x3E, 0x3F, 0x00, 0x01.
- Async reset mid-operation: assert rst=0 between clock edges with count=3. Required: deq_valid=0, count=0, pc_out=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue port bundle: control from the core, instruction-memory request/return,
// and the decode-side head port.
// Decode handshake: an entry transfers on a rising edge where deq_valid=1 and deq_ready=1.
// deq_valid never depends on deq_ready, and the head stays stable until it transfers or is flushed.
interface instr_fetch_queue_if #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               enable;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pc;
  logic [CW-1:0]      count;
  logic [PC_W-1:0]    pc_out;

  // The core/environment side drives control, memory data and decode ready.
  modport master (
    output enable, redirect, redirect_pc, imem_rdata, deq_ready,
    input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc, count, pc_out
  );

  // The fetch queue itself.
  modport slave (
    input  enable, redirect, redirect_pc, imem_rdata, deq_ready,
    output imem_req, imem_addr, deq_valid, deq_instr, deq_pc, count, pc_out
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one-cycle-latency memory reads,
// and buffers returned {instr, pc} pairs in a DEPTH-entry queue toward decode.
module instr_fetch_queue #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_queue_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    fpc;
  logic               infl;
  logic [PC_W-1:0]    infl_pc;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic               has_entry;
  logic               req;
  logic               enq;
  logic               deq;
  logic [CW:0]        credits;

  // A slot is reserved for the in-flight read, so a return can never find the queue full.
  assign credits   = {1'b0, count_q} + {{CW{1'b0}}, infl};
  assign has_entry = (count_q != '0);
  assign req       = rst & bus.enable & ~bus.redirect & (credits < (CW+1)'(DEPTH));
  assign enq       = infl & ~bus.redirect;
  assign deq       = has_entry & bus.deq_ready & ~bus.redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc     <= PC_W'(RESET_PC);
      infl    <= 1'b0;
      infl_pc <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.redirect) begin
      fpc     <= bus.redirect_pc;
      infl    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      infl <= req;
      if (req) begin
        infl_pc <= fpc;
        fpc     <= fpc + PC_W'(PC_STEP);
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the head outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]    <= infl_pc;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fpc;
  assign bus.pc_out    = fpc;
  assign bus.count     = count_q;
  assign bus.deq_valid = has_entry;
  assign bus.deq_instr = has_entry ? instr_mem[rd_ptr] : '0;
  assign bus.deq_pc    = has_entry ? pc_mem[rd_ptr]    : '0;
endmodule
